mu_sweep_ctrl: RTL and testbench

- Upstream controller for the logistic-map display stage.
- Owns the parameter mu (Q2.16) and the iteration count maxrepeat.
- Restarts the logistic cycle engines once per video frame by driving their active-low restart line, then waits for their done.
- Mu is either auto-swept (one step per frame) or stepped manually by debounced buttons.

---
 rtl/mu_sweep_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_mu_sweep_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mu_sweep_ctrl.sv
// mu_sweep_ctrl: owns mu (Q2.16) and maxrepeat for the logistic-map display
// stage and restarts the cycle engines once per video frame.
// Optional feature: define MUSWEEP_PINGPONG_EN to make the auto sweep bounce
// between MU_MIN and MU_MAX instead of wrapping back to MU_MIN.
module mu_sweep_ctrl #(
  parameter logic [17:0] MU_MIN          = 18'h2_0000,
  parameter logic [17:0] MU_MAX          = 18'h3_FFFF,
  parameter logic [17:0] MU_STEP         = 18'h0_0100,
  parameter logic [8:0]  REP_DEFAULT     = 9'd100,
  parameter int unsigned RST_CYCLES      = 4,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        frame_start,
  input  logic        auto_en,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_sel,
  input  logic        done_in,
  output logic [17:0] mu,
  output logic [8:0]  maxrepeat,
  output logic        calc_rst_n,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, UPDATE, PULSE, RUN} state_t;

  localparam logic [3:0]  PULSE_LAST = 4'(RST_CYCLES - 1);
  localparam logic [15:0] DB_LAST    = DEBOUNCE_CYCLES - 16'd1;

  state_t      state;
  state_t      next_state;
  logic [3:0]  pulse_cnt;
  logic        pending_frame;
  logic        calc_rst_n_d;
  logic        busy_d;

  // Button index 0 is "up", index 1 is "down".
  logic [1:0]  btn_raw;
  logic [1:0]  sync1;
  logic [1:0]  sync2;
  logic [1:0]  db_level;
  logic [1:0]  db_level_d;
  logic [15:0] db_cnt [2];
  logic [1:0]  press_evt;

  logic        live_up;
  logic        live_dn;
  logic        up_hold;
  logic        dn_hold;
  logic        param_open;
  logic        hold_phase;
  logic        apply_up;
  logic        apply_dn;

  logic [18:0] mu_sum;
  logic [18:0] mu_diff;
  logic        mu_over;
  logic        mu_under;

`ifdef MUSWEEP_PINGPONG_EN
  logic        dir_up;
`endif

  assign btn_raw = {btn_down, btn_up};

  // Two-flop synchroniser for the raw asynchronous buttons.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after it has differed from the current one for DEBOUNCE_CYCLES.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      db_cnt[0]  <= '0;
      db_cnt[1]  <= '0;
      db_level   <= '0;
      db_level_d <= '0;
    end else begin
      db_level_d <= db_level;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]   <= '0;
          db_level[i] <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign press_evt = db_level & ~db_level_d;

  // Opposing presses in the same cycle cancel each other.
  assign live_up    = press_evt[0] & ~press_evt[1];
  assign live_dn    = press_evt[1] & ~press_evt[0];
  assign hold_phase = (state == PULSE) || (state == RUN);
  assign param_open = (state == IDLE) || (state == UPDATE);
  assign apply_up   = param_open & (live_up | up_hold) & ~(live_dn | dn_hold);
  assign apply_dn   = param_open & (live_dn | dn_hold) & ~(live_up | up_hold);

  // Presses during the restart/run are parked in one-deep flags and released in IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      up_hold <= 1'b0;
      dn_hold <= 1'b0;
    end else if (hold_phase) begin
      if (live_up) up_hold <= 1'b1;
      if (live_dn) dn_hold <= 1'b1;
    end else begin
      up_hold <= 1'b0;
      dn_hold <= 1'b0;
    end
  end

  // State register plus registered outputs, so reset can hold calc_rst_n low.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      calc_rst_n <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      calc_rst_n <= calc_rst_n_d;
      busy       <= busy_d;
    end
  end

  // Next-state logic for the per-frame restart sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (frame_start || pending_frame) next_state = UPDATE;
      UPDATE:  next_state = PULSE;
      PULSE:   if (pulse_cnt == PULSE_LAST) next_state = RUN;
      RUN:     if (done_in) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the upcoming state so outputs line up with the state register.
  always_comb begin
    calc_rst_n_d = (next_state != PULSE);
    busy_d       = (next_state == PULSE) || (next_state == RUN);
  end

  // Pulse length counter and the collapsed pending-frame flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pulse_cnt     <= '0;
      pending_frame <= 1'b0;
    end else begin
      pulse_cnt     <= (state == PULSE) ? pulse_cnt + 4'd1 : 4'd0;
      pending_frame <= (state != IDLE) ? (pending_frame | frame_start) : 1'b0;
    end
  end

  // Step arithmetic in 19 bits so overflow past MU_MAX and borrow below MU_MIN are both visible.
  always_comb begin
    mu_sum   = {1'b0, mu} + {1'b0, MU_STEP};
    mu_diff  = {1'b0, mu} - {1'b0, MU_STEP};
    mu_over  = (mu_sum > {1'b0, MU_MAX});
    mu_under = mu_diff[18] || (mu_diff[17:0] < MU_MIN);
  end

  // mu: auto step in UPDATE, otherwise saturating manual steps while parameters are open.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mu <= MU_MIN;
`ifdef MUSWEEP_PINGPONG_EN
      dir_up <= 1'b1;
`endif
    end else if ((state == UPDATE) && auto_en) begin
`ifdef MUSWEEP_PINGPONG_EN
      if (dir_up) begin
        if (mu_over) begin
          mu     <= MU_MAX;
          dir_up <= 1'b0;
        end else begin
          mu <= mu_sum[17:0];
        end
      end else begin
        if (mu_under) begin
          mu     <= MU_MIN;
          dir_up <= 1'b1;
        end else begin
          mu <= mu_diff[17:0];
        end
      end
`else
      mu <= mu_over ? MU_MIN : mu_sum[17:0];
`endif
    end else if (!auto_en && !btn_sel) begin
      if (apply_up) begin
        mu <= mu_over ? MU_MAX : mu_sum[17:0];
      end else if (apply_dn) begin
        mu <= mu_under ? MU_MIN : mu_diff[17:0];
      end
    end
  end

  // maxrepeat: saturating manual steps between 2 and 511, independent of the sweep mode.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      maxrepeat <= REP_DEFAULT;
    end else if (btn_sel) begin
      if (apply_up && (maxrepeat != 9'd511)) begin
        maxrepeat <= maxrepeat + 9'd1;
      end else if (apply_dn) begin
        maxrepeat <= (maxrepeat > 9'd3) ? maxrepeat - 9'd1 : 9'd2;
      end
    end
  end

endmodule

// File: tb/tb_mu_sweep_ctrl.sv
// Directed testbench for mu_sweep_ctrl using a short debounce time.
module tb_mu_sweep_ctrl;

  localparam int DB = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        frame_start = 1'b0;
  logic        auto_en = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        btn_sel = 1'b0;
  logic        done_in = 1'b0;
  logic [17:0] mu;
  logic [8:0]  maxrepeat;
  logic        calc_rst_n;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int low_cnt;

`ifdef MUSWEEP_PINGPONG_EN
  localparam logic [17:0] MU_AFTER_TOP  = 18'h3_FFFF;
  localparam logic [17:0] MU_AFTER_NEXT = 18'h3_FEFF;
  localparam logic [17:0] MU_T3         = 18'h3_FFFF;
  localparam logic [17:0] MU_HELD       = 18'h3_FFFF;
  localparam logic [17:0] MU_DN1        = 18'h3_FEFF;
  localparam logic [17:0] MU_DN2        = 18'h3_FDFF;
  localparam logic [17:0] MU_DN3        = 18'h3_FCFF;
`else
  localparam logic [17:0] MU_AFTER_TOP  = 18'h2_0000;
  localparam logic [17:0] MU_T3         = 18'h2_0100;
  localparam logic [17:0] MU_HELD       = 18'h2_0200;
  localparam logic [17:0] MU_DN1        = 18'h2_0100;
  localparam logic [17:0] MU_DN2        = 18'h2_0000;
  localparam logic [17:0] MU_DN3        = 18'h2_0000;
`endif

  mu_sweep_ctrl #(
    .DEBOUNCE_CYCLES(16'(DB))
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .frame_start(frame_start),
    .auto_en(auto_en),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_sel(btn_sel),
    .done_in(done_in),
    .mu(mu),
    .maxrepeat(maxrepeat),
    .calc_rst_n(calc_rst_n),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame pulse, leaving the bench one step into UPDATE.
  task automatic applyStimulus();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // A clean debounced press and release of one button.
  task automatic press(input bit is_up);
    if (is_up) btn_up = 1'b1;
    else       btn_down = 1'b1;
    repeat (DB + 3) tick();
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (DB + 3) tick();
  endtask

  initial begin
    // Reset values
    auto_en = 1'b1;
    repeat (2) tick();
    checkOutput("rst_mu", 32'(mu), 32'h2_0000);
    checkOutput("rst_maxrepeat", 32'(maxrepeat), 32'd100);
    checkOutput("rst_calc_rst_n", 32'(calc_rst_n), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    RST = 1'b1;
    tick();
    checkOutput("idle_calc_rst_n", 32'(calc_rst_n), 32'd1);

    // Test 1: one auto frame with a late done_in
    repeat (5) tick();
    applyStimulus();
    checkOutput("t1_update_calc", 32'(calc_rst_n), 32'd1);
    checkOutput("t1_update_mu", 32'(mu), 32'h2_0000);
    tick();
    checkOutput("t1_pulse_mu", 32'(mu), 32'h2_0100);
    checkOutput("t1_pulse_busy", 32'(busy), 32'd1);
    low_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (calc_rst_n == 1'b0) low_cnt++;
      tick();
    end
    checkOutput("t1_pulse_len", 32'(low_cnt), 32'd4);
    checkOutput("t1_run_busy", 32'(busy), 32'd1);
    checkOutput("t1_run_calc", 32'(calc_rst_n), 32'd1);
    repeat (10) tick();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    checkOutput("t1_done_busy", 32'(busy), 32'd0);
    checkOutput("t1_done_calc", 32'(calc_rst_n), 32'd1);

    // Test 2: auto sweep up to the top, then wrap (or bounce)
    done_in = 1'b1;
    applyStimulus();
    repeat (5) tick();
    checkOutput("t2_run_one_cycle_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("t2_idle_busy", 32'(busy), 32'd0);
    checkOutput("t2_mu_step2", 32'(mu), 32'h2_0200);
    for (int k = 0; k < 509; k++) begin
      applyStimulus();
      repeat (6) tick();
    end
    checkOutput("t2_mu_top", 32'(mu), 32'h3_FF00);
    applyStimulus();
    repeat (6) tick();
    checkOutput("t2_mu_wrap", 32'(mu), 32'(MU_AFTER_TOP));
`ifdef MUSWEEP_PINGPONG_EN
    applyStimulus();
    repeat (6) tick();
    checkOutput("t2_mu_bounce", 32'(mu), 32'(MU_AFTER_NEXT));
`endif
    done_in = 1'b0;

    // Test 3: manual mu press, then a short glitch
    auto_en = 1'b0;
    btn_sel = 1'b0;
    press(1'b1);
    repeat (10) tick();
    checkOutput("t3_mu_press", 32'(mu), 32'(MU_T3));
    btn_up = 1'b1;
    repeat (10) tick();
    btn_up = 1'b0;
    repeat (30) tick();
    checkOutput("t3_mu_glitch", 32'(mu), 32'(MU_T3));

    // Press during RUN is held until IDLE
    applyStimulus();
    repeat (5) tick();
    checkOutput("t3_in_run", 32'(busy), 32'd1);
    press(1'b1);
    checkOutput("t3_held_mu", 32'(mu), 32'(MU_T3));
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    tick();
    checkOutput("t3_released_mu", 32'(mu), 32'(MU_HELD));
    press(1'b0);
    checkOutput("t3_down1", 32'(mu), 32'(MU_DN1));
    press(1'b0);
    checkOutput("t3_down2", 32'(mu), 32'(MU_DN2));
    press(1'b0);
    checkOutput("t3_down3", 32'(mu), 32'(MU_DN3));

    // Test 4: maxrepeat saturates at 2
    btn_sel = 1'b1;
    for (int k = 0; k < 96; k++) press(1'b0);
    checkOutput("t4_rep4", 32'(maxrepeat), 32'd4);
    for (int k = 0; k < 5; k++) press(1'b0);
    checkOutput("t4_rep_sat", 32'(maxrepeat), 32'd2);
    press(1'b1);
    checkOutput("t4_rep_up", 32'(maxrepeat), 32'd3);
    checkOutput("t4_mu_unchanged", 32'(mu), 32'(MU_DN3));
    btn_sel = 1'b0;

    // Test 5: two frames during RUN collapse to one extra sequence
    applyStimulus();
    repeat (5) tick();
    checkOutput("t5_in_run", 32'(busy), 32'd1);
    applyStimulus();
    repeat (3) tick();
    applyStimulus();
    repeat (3) tick();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    checkOutput("t5_idle_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("t5_update_calc", 32'(calc_rst_n), 32'd1);
    tick();
    checkOutput("t5_pulse_calc", 32'(calc_rst_n), 32'd0);
    repeat (4) tick();
    checkOutput("t5_run_calc", 32'(calc_rst_n), 32'd1);
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (calc_rst_n == 1'b0) low_cnt++;
      tick();
    end
    checkOutput("t5_no_extra_pulse", 32'(low_cnt), 32'd0);
    checkOutput("t5_final_busy", 32'(busy), 32'd0);

    // Test 6: reset in the middle of PULSE
    auto_en = 1'b1;
    applyStimulus();
    tick();
    RST = 1'b0;
    #1;
    checkOutput("t6_rst_mu", 32'(mu), 32'h2_0000);
    checkOutput("t6_rst_maxrepeat", 32'(maxrepeat), 32'd100);
    checkOutput("t6_rst_calc", 32'(calc_rst_n), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    #3;
    RST = 1'b1;
    tick();
    checkOutput("t6_idle_calc", 32'(calc_rst_n), 32'd1);
    applyStimulus();
    tick();
    checkOutput("t6_frame_mu", 32'(mu), 32'h2_0100);
    checkOutput("t6_frame_calc", 32'(calc_rst_n), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
